// File: rtl/serial_or_reducer.sv
// Frame reducer for a 1-bit beat stream: folds each frame into OR, AND, popcount
// and length, and presents the result through a one-entry registered buffer.
module serial_or_reducer #(
  parameter int FRAME_LEN = 8,
  localparam int CNT_W = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic             up_data,
  input  logic             up_last,
  output logic             down_valid,
  input  logic             down_ready,
  output logic             down_or,
  output logic             down_and,
  output logic [CNT_W-1:0] down_ones,
  output logic [CNT_W-1:0] down_len
);

  typedef enum logic [0:0] {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  buf_state_e       state_r;
  buf_state_e       state_s;
  logic             acc_or_r;
  logic             acc_and_r;
  logic [CNT_W-1:0] acc_ones_r;
  logic [CNT_W-1:0] acc_len_r;
  logic             accept_s;
  logic             close_s;
  logic [CNT_W-1:0] data_ext_s;

  // A full buffer can only accept a beat if it is being drained this same cycle
  assign up_ready   = (state_r == BUF_EMPTY) || down_ready;
  assign down_valid = (state_r == BUF_FULL);

  // Beat acceptance, frame-close detection and output buffer next state
  always_comb begin
    accept_s   = up_valid && up_ready;
    close_s    = 1'b0;
    state_s    = state_r;
    data_ext_s = {{(CNT_W-1){1'b0}}, up_data};
    if (accept_s) begin
      close_s = up_last || (acc_len_r == LAST_IDX);
    end else begin
      close_s = 1'b0;
    end
    case (state_r)
      BUF_EMPTY: begin
        if (close_s) state_s = BUF_FULL;
        else         state_s = BUF_EMPTY;
      end
      BUF_FULL: begin
        if (close_s)         state_s = BUF_FULL;
        else if (down_ready) state_s = BUF_EMPTY;
        else                 state_s = BUF_FULL;
      end
      default: state_s = BUF_EMPTY;
    endcase
  end

  // Accumulators and output buffer; a closing beat is folded straight into the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= BUF_EMPTY;
      acc_or_r   <= 1'b0;
      acc_and_r  <= 1'b1;
      acc_ones_r <= {CNT_W{1'b0}};
      acc_len_r  <= {CNT_W{1'b0}};
      down_or    <= 1'b0;
      down_and   <= 1'b0;
      down_ones  <= {CNT_W{1'b0}};
      down_len   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (close_s) begin
        down_or    <= acc_or_r | up_data;
        down_and   <= acc_and_r & up_data;
        down_ones  <= acc_ones_r + data_ext_s;
        down_len   <= acc_len_r + ONE;
        acc_or_r   <= 1'b0;
        acc_and_r  <= 1'b1;
        acc_ones_r <= {CNT_W{1'b0}};
        acc_len_r  <= {CNT_W{1'b0}};
      end else if (accept_s) begin
        acc_or_r   <= acc_or_r | up_data;
        acc_and_r  <= acc_and_r & up_data;
        acc_ones_r <= acc_ones_r + data_ext_s;
        acc_len_r  <= acc_len_r + ONE;
      end
    end
  end

endmodule
